// File: rtl/fic_apb_arbiter.sv
// Round-robin arbiter that shares one APB3 master port (FIC bus) among NREQ requesters.
// One single-beat transfer at a time. Completion returns read data and an error flag.
module fic_apb_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               SYSCLK,
  input  logic               NSYSRESET,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    wr_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic [DW-1:0]      rdata_o,
  output logic               err_o,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [AW-1:0]      PADDR,
  output logic [DW-1:0]      PWDATA,
  input  logic               PREADY,
  input  logic [DW-1:0]      PRDATA,
  input  logic               PSLVERR
);

  localparam int            IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW:0]   NREQ_W  = (IW + 1)'(NREQ);
  localparam logic [IW-1:0] LAST_IX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [CW-1:0]   to_cnt;

  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [IW:0]     cand;

  // Cyclic scan starting at ptr: the first asserted request wins.
  // NOTE: every variable gets a default before the loop so no path can infer a latch.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IW + 1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_valid && req_i[cand[IW-1:0]]) begin
        win_valid                = 1'b1;
        win_idx                  = cand[IW-1:0];
        win_onehot[cand[IW-1:0]] = 1'b1;
      end
    end
  end

  // NOTE: state and outputs are registers, so every assignment here is non-blocking.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      to_cnt  <= '0;
      gnt_o   <= '0;
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            gidx   <= win_idx;
            gnt_o  <= win_onehot;
            PSEL   <= 1'b1;
            PWRITE <= wr_i[win_idx];
            PADDR  <= addr_i[win_idx*AW +: AW];
            PWDATA <= wdata_i[win_idx*DW +: DW];
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          to_cnt  <= '0;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            gnt_o   <= '0;
            done_o  <= gnt_o;
            err_o   <= PSLVERR;
            rdata_o <= PWRITE ? '0 : PRDATA;
            to_cnt  <= '0;
            state   <= ST_DONE;
          end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
            // This was the TIMEOUT-th stalled ACCESS cycle: abort with an error.
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            gnt_o   <= '0;
            done_o  <= gnt_o;
            err_o   <= 1'b1;
            rdata_o <= '0;
            to_cnt  <= '0;
            state   <= ST_DONE;
          end else if (TIMEOUT != 0) begin
            to_cnt <= to_cnt + CW'(1);
          end
        end

        ST_DONE: begin
          done_o  <= '0;
          err_o   <= 1'b0;
          rdata_o <= '0;
          ptr     <= (gidx == LAST_IX) ? '0 : gidx + IW'(1);
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fic_apb_arbiter.sv
// Scoreboard bench for fic_apb_arbiter: stimulus pushes expectations, a monitor pops
// them when the DUT starts a SETUP phase or pulses done_o.
module tb_fic_apb_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 8;

  logic               SYSCLK;
  logic               NSYSRESET;
  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    wr_i;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ*DW-1:0] wdata_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    done_o;
  logic [DW-1:0]      rdata_o;
  logic               err_o;
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [AW-1:0]      PADDR;
  logic [DW-1:0]      PWDATA;
  logic               PREADY;
  logic [DW-1:0]      PRDATA;
  logic               PSLVERR;

  fic_apb_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [NREQ-1:0] done;
    logic            err;
    logic [DW-1:0]   rdata;
    int              acc;
  } sb_t;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
  } apb_t;

  sb_t  sb_q[$];
  apb_t apb_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          s_waits  = 0;
  logic [31:0] s_prdata = '0;
  logic        s_slverr = 1'b0;
  logic        s_hang   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    SYSCLK = 1'b0;
    forever #5 SYSCLK = ~SYSCLK;
  end

  always @(posedge SYSCLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  // APB slave: PREADY rises on ACCESS cycle s_waits+1 unless hung; junk outside ACCESS.
  initial begin : slave
    int acc_n;
    acc_n   = 0;
    PREADY  = 1'b1;
    PRDATA  = 32'hFFFF_FFFF;
    PSLVERR = 1'b1;
    forever begin
      @(negedge SYSCLK);
      if (PSEL && PENABLE) begin
        acc_n++;
        PREADY  = !s_hang && (acc_n == s_waits + 1);
        PRDATA  = PREADY ? s_prdata : 32'hBAD0_0000 + 32'(acc_n);
        PSLVERR = PREADY ? s_slverr : 1'b1;
      end else begin
        acc_n   = 0;
        PREADY  = 1'b1;
        PRDATA  = 32'hFFFF_FFFF;
        PSLVERR = 1'b1;
      end
    end
  end

  // Monitor: checks each SETUP against apb_q and each done pulse against sb_q.
  initial begin : monitor
    sb_t             e;
    apb_t            a;
    apb_t            cur;
    int              en_cnt;
    int              setup_cyc;
    logic [NREQ-1:0] prev_done;
    en_cnt    = 0;
    setup_cyc = 0;
    prev_done = '0;
    cur       = '{gnt: '0, wr: 1'b0, addr: '0, wdata: '0};
    forever begin
      @(negedge SYSCLK);
      if (!NSYSRESET) begin
        en_cnt    = 0;
        prev_done = '0;
      end else begin
        if (gnt_o != '0) check("gnt_onehot", 32'($onehot(gnt_o)), 32'd1);
        if (PENABLE) check("penable_implies_psel", 32'(PSEL), 32'd1);
        if (prev_done != '0) check("done_single_cycle", 32'(done_o), 32'd0);
        if (PSEL && !PENABLE) begin
          if (apb_q.size() == 0) begin
            check("unexpected_setup", 32'(PSEL), 32'd0);
          end else begin
            a = apb_q.pop_front();
            check("setup_gnt", 32'(gnt_o), 32'(a.gnt));
            check("setup_pwrite", 32'(PWRITE), 32'(a.wr));
            check("setup_paddr", PADDR, a.addr);
            check("setup_pwdata", PWDATA, a.wdata);
            cur       = a;
            setup_cyc = cyc;
            en_cnt    = 0;
          end
        end
        if (PENABLE) begin
          en_cnt++;
          check("access_paddr_stable", PADDR, cur.addr);
          check("access_pwdata_stable", PWDATA, cur.wdata);
          check("access_gnt_held", 32'(gnt_o), 32'(cur.gnt));
        end
        if (done_o != '0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(done_o), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("done_onehot", 32'(done_o), 32'(e.done));
            check("done_err", 32'(err_o), 32'(e.err));
            check("done_rdata", rdata_o, e.rdata);
            check("done_access_cycles", 32'(en_cnt), 32'(e.acc));
            check("done_latency", 32'(cyc - setup_cyc), 32'(e.acc + 1));
            check("done_psel_low", 32'({PSEL, PENABLE}), 32'd0);
            check("done_gnt_low", 32'(gnt_o), 32'd0);
          end
        end
        prev_done = done_o;
      end
    end
  end

  task automatic expect_xfer(input int k, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic exp_err,
                             input logic [DW-1:0] exp_rdata, input int exp_acc);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    apb_q.push_back('{gnt: oh, wr: wr, addr: addr, wdata: wdata});
    sb_q.push_back('{done: oh, err: exp_err, rdata: exp_rdata, acc: exp_acc});
  endtask

  task automatic set_slave(input int waits, input logic [31:0] prd, input logic slverr,
                           input logic hang);
    s_waits  = waits;
    s_prdata = prd;
    s_slverr = slverr;
    s_hang   = hang;
  endtask

  // Single requester transfer; called at a negedge. Inputs are scrambled after grant.
  task automatic issue(input int k, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int waits, input logic [31:0] prd,
                       input logic slverr, input logic hang, input logic exp_err,
                       input logic [DW-1:0] exp_rdata, input int exp_acc);
    bit got;
    set_slave(waits, prd, slverr, hang);
    expect_xfer(k, wr, addr, wdata, exp_err, exp_rdata, exp_acc);
    wr_i[k]               = wr;
    addr_i[k*AW +: AW]    = addr;
    wdata_i[k*DW +: DW]   = wdata;
    req_i[k]              = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge SYSCLK);
      got = gnt_o[k];
    end
    req_i[k] = 1'b0;
    if (!got) begin
      check("gnt_wait", 32'(gnt_o), 32'(1 << k));
      return;
    end
    addr_i[k*AW +: AW]  = ~addr;
    wdata_i[k*DW +: DW] = ~wdata;
    wr_i[k]             = ~wr;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge SYSCLK);
      got = done_o[k];
    end
    if (!got) check("done_wait", 32'(done_o), 32'(1 << k));
  endtask

  initial begin : stimulus
    bit got;
    NSYSRESET = 1'b0;
    req_i     = '0;
    wr_i      = '0;
    addr_i    = '0;
    wdata_i   = '0;
    @(posedge SYSCLK);
    @(negedge SYSCLK);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_apb_ctrl", 32'({PSEL, PENABLE, PWRITE, err_o}), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    NSYSRESET = 1'b1;
    @(negedge SYSCLK);

    // T1: write, zero wait states, cycle-exact phase checks.
    set_slave(0, 32'h0, 1'b0, 1'b0);
    expect_xfer(0, 1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0, 1);
    wr_i[0]          = 1'b1;
    addr_i[0 +: AW]  = 32'h4000_0000;
    wdata_i[0 +: DW] = 32'hDEAD_BEEF;
    req_i[0]         = 1'b1;
    @(posedge SYSCLK); #1;
    check("t1_c1_setup", 32'({PSEL, PENABLE, PWRITE}), 32'b101);
    check("t1_c1_gnt", 32'(gnt_o), 32'b0001);
    req_i[0] = 1'b0;
    @(posedge SYSCLK); #1;
    check("t1_c2_access", 32'({PSEL, PENABLE}), 32'b11);
    @(posedge SYSCLK); #1;
    check("t1_c3_done", 32'(done_o), 32'b0001);
    check("t1_c3_err", 32'(err_o), 32'd0);
    @(posedge SYSCLK); #1;
    check("t1_c4_done_clear", 32'(done_o), 32'd0);
    @(negedge SYSCLK);

    // T2: read with 3 wait states (PENABLE high 4 cycles).
    issue(1, 1'b0, 32'h4000_1004, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 4);
    // T5: slave error on a read still returns PRDATA.
    issue(2, 1'b0, 32'h4000_2008, 32'h1111_2222, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 2);
    // T4: PREADY never rises; abort after TO ACCESS cycles.
    issue(3, 1'b1, 32'h4000_300C, 32'h0BAD_C0DE, 0, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1, 32'h0, TO);

    // T3: all four request together; pointer is back at 0, so order is 0,1,2,3,0.
    set_slave(0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < NREQ; k++) begin
      wr_i[k]             = 1'b1;
      addr_i[k*AW +: AW]  = 32'h5000_0000 + 32'(k * 4);
      wdata_i[k*DW +: DW] = 32'hA0 + 32'(k);
    end
    expect_xfer(0, 1'b1, 32'h5000_0000, 32'hA0, 1'b0, 32'h0, 1);
    expect_xfer(1, 1'b1, 32'h5000_0004, 32'hA1, 1'b0, 32'h0, 1);
    expect_xfer(2, 1'b1, 32'h5000_0008, 32'hA2, 1'b0, 32'h0, 1);
    expect_xfer(3, 1'b1, 32'h5000_000C, 32'hA3, 1'b0, 32'h0, 1);
    expect_xfer(0, 1'b1, 32'h5000_0000, 32'hA0, 1'b0, 32'h0, 1);
    req_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
        @(negedge SYSCLK);
        got = (done_o != '0);
      end
      if (!got) check("t3_done_wait", 32'(done_o), 32'd1);
      req_i = (t == 4) ? '0 : req_i & ~done_o;
      if (t < 4) begin
        @(negedge SYSCLK);
        req_i = 4'b1111;
      end
    end
    @(negedge SYSCLK);

    // T6: asynchronous reset while a transfer is stuck in ACCESS.
    set_slave(0, 32'h0, 1'b0, 1'b1);
    apb_q.push_back('{gnt: 4'b0100, wr: 1'b0, addr: 32'h4000_2000, wdata: 32'h0});
    wr_i[2]             = 1'b0;
    addr_i[2*AW +: AW]  = 32'h4000_2000;
    wdata_i[2*DW +: DW] = 32'h0;
    req_i[2]            = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge SYSCLK);
      got = PENABLE;
    end
    check("t6_in_access", 32'(PENABLE), 32'd1);
    req_i = '0;
    @(negedge SYSCLK);
    #2 NSYSRESET = 1'b0;
    #1;
    check("t6_async_apb", 32'({PSEL, PENABLE}), 32'd0);
    check("t6_async_gnt", 32'(gnt_o), 32'd0);
    check("t6_async_done", 32'(done_o), 32'd0);
    @(posedge SYSCLK);
    @(negedge SYSCLK);
    NSYSRESET = 1'b1;
    issue(2, 1'b1, 32'h4000_2010, 32'h5A5A_5A5A, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1);

    repeat (3) @(negedge SYSCLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("apb_drained", 32'(apb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
